// File: rtl/f1_pkg.sv
// Shared definitions for the F1 start-lights reaction timer: FSM states and
// the two light patterns that drive arming and the start of a run.
package f1_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_RUNNING = 3'd2,
    ST_DONE    = 3'd3,
    ST_FOUL    = 3'd4
  } f1_state_t;

  localparam logic [7:0] LIGHTS_OFF = 8'h00;
  localparam logic [7:0] LIGHTS_ALL = 8'hFF;

  function automatic logic state_is_busy(input f1_state_t s);
    return (s == ST_ARMED) || (s == ST_RUNNING);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// 0->1 edge detector: one history register, rise is high in the cycle the
// input is first seen high after having been sampled low.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/f1_reaction_timer.sv
// Reaction timer: arms on the start-lights sequence, counts ms ticks from
// lights-out until the button press, flags jump starts and timeouts.
module f1_reaction_timer
  import f1_pkg::*;
#(
  parameter int unsigned TIMEOUT_MS = 5000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       lights,
  input  logic             tick_ms,
  input  logic             btn,
  output logic [CNT_W-1:0] time_ms,
  output logic             valid,
  output logic             jump_start,
  output logic             timeout,
  output logic             busy,
  output f1_state_t        state_dbg
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_MS);

  f1_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             full_seen_q;
  logic [CNT_W-1:0] time_q;
  logic             valid_q;
  logic             jump_q;
  logic             timeout_q;
  logic             press;
  logic [CNT_W-1:0] cnt_inc;

  rise_detect u_btn_rise (
    .clk    (clk),
    .rst    (rst),
    .d_i    (btn),
    .rise_o (press)
  );

  // A tick in the same cycle as the press or the timeout still counts.
  assign cnt_inc = cnt_q + CNT_W'(tick_ms);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      full_seen_q <= 1'b0;
      time_q      <= '0;
      valid_q     <= 1'b0;
      jump_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_FOUL: begin
          if (lights != LIGHTS_OFF) begin
            state_q     <= ST_ARMED;
            full_seen_q <= 1'b0;
            jump_q      <= 1'b0;
            timeout_q   <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (press) begin
            state_q <= ST_FOUL;
            jump_q  <= 1'b1;
            time_q  <= '0;
            valid_q <= 1'b1;
          end else if (lights == LIGHTS_OFF) begin
            // Lights going out without ever being fully lit aborts the round.
            if (full_seen_q) begin
              state_q <= ST_RUNNING;
              cnt_q   <= '0;
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (lights == LIGHTS_ALL) begin
            full_seen_q <= 1'b1;
          end
        end
        ST_RUNNING: begin
          if (press) begin
            state_q <= ST_DONE;
            time_q  <= cnt_inc;
            valid_q <= 1'b1;
          end else if (cnt_inc >= TIMEOUT_C) begin
            state_q   <= ST_DONE;
            time_q    <= TIMEOUT_C;
            timeout_q <= 1'b1;
            valid_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign time_ms    = time_q;
  assign valid      = valid_q;
  assign jump_start = jump_q;
  assign timeout    = timeout_q;
  assign busy       = state_is_busy(state_q);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Bench for f1_reaction_timer: per-cycle vector table, directed multi-cycle
// scenarios, then random rounds checked against a round-level result model.
module tb_f1_reaction_timer;
  import f1_pkg::*;

  localparam int TIMEOUT = 5000;
  localparam int W       = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   lights;
  logic         tick_ms;
  logic         btn;
  logic [W-1:0] time_ms;
  logic         valid;
  logic         jump_start;
  logic         timeout;
  logic         busy;
  f1_state_t    state_dbg;

  int checks    = 0;
  int errors    = 0;
  int valid_cnt = 0;
  bit mon_en    = 1'b0;
  // expected result record: {jump_start, timeout, time_ms}
  logic [W+1:0] exp_q[$];

  f1_reaction_timer #(.TIMEOUT_MS(TIMEOUT), .CNT_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .lights     (lights),
    .tick_ms    (tick_ms),
    .btn        (btn),
    .time_ms    (time_ms),
    .valid      (valid),
    .jump_start (jump_start),
    .timeout    (timeout),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: inputs already driven; outputs sampled 1 time unit after the edge.
  task automatic step();
    logic [W+1:0] e;
    @(posedge clk);
    #1;
    if (valid) begin
      valid_cnt++;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got valid=1 expected no result (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("res_time", time_ms, e[W-1:0]);
          check("res_timeout", timeout, e[W]);
          check("res_jump", jump_start, e[W+1]);
        end
      end
    end
  endtask

  function automatic logic [7:0] light_val(input int i);
    logic [8:0] v;
    v = (9'd1 << (i + 1)) - 9'd1;
    return v[7:0];
  endfunction

  // Full start sequence 01,03..FF then lights out; leaves the timer running at 0.
  task automatic lights_seq();
    tick_ms = 1'b0;
    for (int i = 0; i < 8; i++) begin
      lights = light_val(i);
      step();
    end
    lights = 8'h00;
    step();
  endtask

  task automatic lights_partial_rand(input int n);
    for (int i = 0; i < n; i++) begin
      lights = light_val(i);
      repeat ($urandom_range(1, 3)) begin
        tick_ms = 1'($urandom_range(0, 1));
        step();
      end
    end
  endtask

  typedef struct {
    logic         rst;
    logic [7:0]   lights;
    logic         tick;
    logic         btn;
    logic         valid;
    logic [W-1:0] time_v;
    logic         jump;
    logic         tmo;
    logic         busy;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int v0;
    int sum;
    int k;
    int kind;
    int s;

    rst = 1'b1; lights = 8'h00; tick_ms = 1'b0; btn = 1'b0;

    // ---- table-driven vectors, one row per clock ----
    vecs[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 8'h07, 1'b0, 1'b1, 1'b1, 16'd0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 16'd2, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'd2, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 16'd2, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd2, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'd2, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 17; i++) begin
      rst     = vecs[i].rst;
      lights  = vecs[i].lights;
      tick_ms = vecs[i].tick;
      btn     = vecs[i].btn;
      step();
      check($sformatf("vec%0d_valid", i), valid, vecs[i].valid);
      check($sformatf("vec%0d_time", i), time_ms, vecs[i].time_v);
      check($sformatf("vec%0d_jump", i), jump_start, vecs[i].jump);
      check($sformatf("vec%0d_timeout", i), timeout, vecs[i].tmo);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
    end
    btn = 1'b0; tick_ms = 1'b0;
    step();

    // ---- 237 ms reaction ----
    lights_seq();
    v0 = valid_cnt;
    tick_ms = 1'b1;
    repeat (237) step();
    tick_ms = 1'b0; btn = 1'b1;
    step();
    check("r237_valid", valid, 1'b1);
    check("r237_time", time_ms, 237);
    check("r237_jump", jump_start, 1'b0);
    check("r237_timeout", timeout, 1'b0);
    btn = 1'b0;
    step();
    check("r237_valid_once", valid_cnt, v0 + 1);
    check("r237_busy", busy, 1'b0);

    // ---- lights changing while running are ignored ----
    lights_seq();
    lights = 8'h55; tick_ms = 1'b1;
    repeat (10) step();
    check("run_ign_busy", busy, 1'b1);
    lights = 8'h00; tick_ms = 1'b0; btn = 1'b1;
    step();
    check("run_ign_time", time_ms, 10);
    btn = 1'b0;
    step();

    // ---- press on the 38th tick, then btn held through the next round ----
    lights_seq();
    tick_ms = 1'b1;
    repeat (37) step();
    btn = 1'b1;
    step();
    check("t38_valid", valid, 1'b1);
    check("t38_time", time_ms, 38);
    v0 = valid_cnt;
    tick_ms = 1'b0;
    step();
    lights_seq();
    tick_ms = 1'b1;
    repeat (20) step();
    check("held_no_press", valid_cnt, v0);
    check("held_busy", busy, 1'b1);
    btn = 1'b0;
    step();
    tick_ms = 1'b0; btn = 1'b1;
    step();
    check("after_release_time", time_ms, 21);
    btn = 1'b0;
    step();

    // ---- timeout with no press ----
    lights_seq();
    v0 = valid_cnt;
    tick_ms = 1'b1;
    repeat (TIMEOUT - 1) step();
    check("tmo_no_early_valid", valid_cnt, v0);
    check("tmo_busy_before", busy, 1'b1);
    step();
    check("tmo_valid", valid, 1'b1);
    check("tmo_time", time_ms, TIMEOUT);
    check("tmo_flag", timeout, 1'b1);
    check("tmo_jump", jump_start, 1'b0);
    tick_ms = 1'b0;
    step();
    check("tmo_flag_level", timeout, 1'b1);
    check("tmo_busy_after", busy, 1'b0);

    // ---- press coinciding with the timeout tick ----
    lights_seq();
    check("rearm_clears_timeout", timeout, 1'b0);
    tick_ms = 1'b1;
    repeat (TIMEOUT - 1) step();
    btn = 1'b1;
    step();
    check("tie_valid", valid, 1'b1);
    check("tie_time", time_ms, TIMEOUT);
    check("tie_timeout", timeout, 1'b0);
    btn = 1'b0; tick_ms = 1'b0;
    step();

    // ---- reset mid-run abandons the run ----
    lights_seq();
    tick_ms = 1'b1;
    repeat (100) step();
    v0 = valid_cnt;
    rst = 1'b1;
    step();
    check("rst_time", time_ms, 0);
    check("rst_valid", valid, 1'b0);
    check("rst_jump", jump_start, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0; tick_ms = 1'b0;
    repeat (3) step();
    check("rst_no_valid", valid_cnt, v0);
    check("rst_stays_idle", busy, 1'b0);

    // ---- btn held through reset is not a press; then an aborted sequence ----
    rst = 1'b1; btn = 1'b1;
    step();
    rst = 1'b0; lights = 8'h01;
    step();
    lights = 8'h03;
    step();
    step();
    check("held_rst_busy", busy, 1'b1);
    check("held_rst_jump", jump_start, 1'b0);
    btn = 1'b0; lights = 8'h00;
    step();
    check("abort_busy", busy, 1'b0);
    check("abort_no_valid", valid_cnt, v0);

    // ---- random rounds against the result model ----
    mon_en = 1'b1;
    for (int r = 0; r < 40; r++) begin
      kind = $urandom_range(0, 9);
      if (kind < 2) begin
        // abort: never reaches all-lit, so no result
        s = $urandom_range(1, 7);
        lights_partial_rand(s);
        lights = 8'h00; tick_ms = 1'($urandom_range(0, 1));
        step();
        check("rnd_abort_busy", busy, 1'b0);
      end else if (kind < 4) begin
        // jump start while the lights are still on
        s = $urandom_range(1, 7);
        lights_partial_rand(s);
        lights = light_val(s); btn = 1'b1; tick_ms = 1'($urandom_range(0, 1));
        exp_q.push_back({1'b1, 1'b0, 16'd0});
        step();
        btn = 1'b0; lights = 8'h00;
        step();
        step();
        check("rnd_foul_jump_level", jump_start, 1'b1);
        check("rnd_foul_busy", busy, 1'b0);
      end else begin
        // normal round: result = ticks seen after lights out, press cycle included
        lights_partial_rand(8);
        lights = 8'h00; tick_ms = 1'($urandom_range(0, 1));
        step();
        k = $urandom_range(1, 300);
        sum = 0;
        repeat (k - 1) begin
          tick_ms = 1'($urandom_range(0, 1));
          sum += int'(tick_ms);
          step();
        end
        tick_ms = 1'($urandom_range(0, 1));
        sum += int'(tick_ms);
        btn = 1'b1;
        exp_q.push_back({1'b0, (sum >= TIMEOUT) ? 1'b0 : 1'b0, 16'((sum > TIMEOUT) ? TIMEOUT : sum)});
        step();
        btn = 1'b0; tick_ms = 1'b0;
        step();
        check("rnd_done_busy", busy, 1'b0);
      end
      // idle gap with stray presses that must be ignored
      lights = 8'h00;
      repeat ($urandom_range(1, 5)) begin
        btn     = 1'($urandom_range(0, 1));
        tick_ms = 1'($urandom_range(0, 1));
        step();
      end
      btn = 1'b0;
      step();
    end
    mon_en = 1'b0;
    check("exp_queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
